// File: rtl/vga_scaled_addr_gen_if.sv
// Position-in / address-out bundle between the VGA timing driver, vga_scaled_addr_gen and the RAM read port.
// With VGA_SCALED_MIRROR_EN defined the bundle also carries the per-frame mirror request.
interface vga_scaled_addr_gen_if #(
    parameter int AW = 8
);
    logic [11:0]   pos_x;
    logic [11:0]   pos_y;
    logic [AW-1:0] mem_addr;
    logic          in_image;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_SCALED_MIRROR_EN
    logic          mirror;

    modport master (output pos_x, pos_y, mirror,
                    input  mem_addr, in_image, line_start, frame_start);
    modport slave  (input  pos_x, pos_y, mirror,
                    output mem_addr, in_image, line_start, frame_start);
`else
    modport master (output pos_x, pos_y,
                    input  mem_addr, in_image, line_start, frame_start);
    modport slave  (input  pos_x, pos_y,
                    output mem_addr, in_image, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_scaled_addr_gen.sv
// Frame-buffer read address generator for an integer-upscaled image, built from counters only (no divider/multiplier).
// Optional horizontal mirroring, latched once per frame, is enabled by defining VGA_SCALED_MIRROR_EN.
module vga_scaled_addr_gen #(
    parameter int SCREEN_X = 1024,
    parameter int SCREEN_Y = 768,
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 12,
    parameter int AW       = 8,
    parameter int SCALE_X  = 64,
    parameter int SCALE_Y  = 64,
    parameter int RD_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_scaled_addr_gen_if.slave bus
);
    localparam int SXW = $clog2(SCALE_X + 1);
    localparam int SYW = $clog2(SCALE_Y + 1);
    localparam int CW  = $clog2(IMG_W + 1);
    localparam int RW  = $clog2(IMG_H + 1);

    localparam logic [SXW-1:0] SX_LAST  = SXW'(SCALE_X - 1);
    localparam logic [SYW-1:0] SY_LAST  = SYW'(SCALE_Y - 1);
    localparam logic [CW-1:0]  COL_END  = CW'(IMG_W);
    localparam logic [RW-1:0]  ROW_END  = RW'(IMG_H);
    localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
    localparam logic [AW-1:0]  ROW_STEP = AW'(IMG_W);
    localparam logic [AW-1:0]  COL_LAST = AW'(IMG_W - 1);

    // IDLE after reset until a frame start, so no partial frame is ever addressed.
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    state_t state, state_nx;

    logic [SXW-1:0] sub_x, sub_x_nx;
    logic [CW-1:0]  col, col_nx;
    logic [SYW-1:0] sub_y, sub_y_nx;
    logic [RW-1:0]  row, row_nx;
    logic [AW-1:0]  row_base, row_base_nx;
    logic [11:0]    prev_y;
    logic           line_start_nx, frame_start_nx;
    logic           active, frame_hit, line_hit, pixel_hit;
    logic           in_image_raw;
    logic [AW-1:0]  col_clamp, col_eff, mem_addr_nx;
    logic [AW-1:0]  mem_addr_q;
    logic           line_start_q, frame_start_q;
    logic [RD_LAT:0] img_dly;

    assign active    = (bus.pos_x < 12'(SCREEN_X)) && (bus.pos_y < 12'(SCREEN_Y));
    assign frame_hit = (bus.pos_x == '0) && (bus.pos_y == '0);
    assign line_hit  = active && (bus.pos_x == '0) && (bus.pos_y != prev_y) && (bus.pos_y != '0);
    assign pixel_hit = active && (bus.pos_x != '0);

`ifdef VGA_SCALED_MIRROR_EN
    logic mirror_q, mirror_nx;
    assign mirror_nx = frame_hit ? bus.mirror : mirror_q;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nx       = state;
        sub_x_nx       = sub_x;
        col_nx         = col;
        sub_y_nx       = sub_y;
        row_nx         = row;
        row_base_nx    = row_base;
        line_start_nx  = 1'b0;
        frame_start_nx = 1'b0;

        // Priority: frame start, then line advance, then pixel advance.
        if (frame_hit) begin
            state_nx       = ST_RUN;
            sub_x_nx       = '0;
            col_nx         = '0;
            sub_y_nx       = '0;
            row_nx         = '0;
            row_base_nx    = '0;
            frame_start_nx = 1'b1;
        end else if (state == ST_RUN) begin
            if (line_hit) begin
                line_start_nx = 1'b1;
                sub_x_nx      = '0;
                col_nx        = '0;
                if (sub_y == SY_LAST) begin
                    sub_y_nx = '0;
                    if (row != ROW_END) row_nx = row + 1'b1;
                    // row_base stops on the last image row so a saturated row keeps a legal address.
                    if (row < ROW_LAST) row_base_nx = row_base + ROW_STEP;
                end else begin
                    sub_y_nx = sub_y + 1'b1;
                end
            end else if (pixel_hit) begin
                if (sub_x == SX_LAST) begin
                    sub_x_nx = '0;
                    if (col != COL_END) col_nx = col + 1'b1;
                end else begin
                    sub_x_nx = sub_x + 1'b1;
                end
            end
        end
    end

    // Address and region flag come from the post-update counters, giving one cycle of latency.
    always_comb begin
        col_clamp = (col_nx >= COL_END) ? COL_LAST : AW'(col_nx);
`ifdef VGA_SCALED_MIRROR_EN
        col_eff   = mirror_nx ? (COL_LAST - col_clamp) : col_clamp;
`else
        col_eff   = col_clamp;
`endif
        mem_addr_nx  = row_base_nx + col_eff;
        in_image_raw = (state_nx == ST_RUN) && active && (col_nx < COL_END) && (row_nx < ROW_END);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state         <= ST_IDLE;
            sub_x         <= '0;
            col           <= '0;
            sub_y         <= '0;
            row           <= '0;
            row_base      <= '0;
            prev_y        <= '0;
            mem_addr_q    <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            img_dly       <= '0;
`ifdef VGA_SCALED_MIRROR_EN
            mirror_q      <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            sub_x         <= sub_x_nx;
            col           <= col_nx;
            sub_y         <= sub_y_nx;
            row           <= row_nx;
            row_base      <= row_base_nx;
            prev_y        <= bus.pos_y;
            mem_addr_q    <= mem_addr_nx;
            line_start_q  <= line_start_nx;
            frame_start_q <= frame_start_nx;
            img_dly[0]    <= in_image_raw;
            for (int i = 1; i <= RD_LAT; i++) img_dly[i] <= img_dly[i-1];
`ifdef VGA_SCALED_MIRROR_EN
            mirror_q      <= mirror_nx;
`endif
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.in_image    = img_dly[RD_LAT];
endmodule

// File: tb/tb_vga_scaled_addr_gen.sv
// Randomized bench for vga_scaled_addr_gen: two instances (default scaling, and 32x3 with zero read latency) share one scan.
// Expected outputs come from line/pixel event counts and integer division; mirror paths need VGA_SCALED_MIRROR_EN.
module tb_vga_scaled_addr_gen;
    localparam int SCREEN_X = 1024;
    localparam int SCREEN_Y = 768;
    localparam int IMG_W    = 16;
    localparam int IMG_H    = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pos_x = '0;
    logic [11:0] pos_y = '0;
    logic        mirror = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_scaled_addr_gen_if #(.AW(8)) if_a ();
    vga_scaled_addr_gen_if #(.AW(8)) if_b ();

    assign if_a.pos_x = pos_x;
    assign if_a.pos_y = pos_y;
    assign if_b.pos_x = pos_x;
    assign if_b.pos_y = pos_y;
`ifdef VGA_SCALED_MIRROR_EN
    assign if_a.mirror = mirror;
    assign if_b.mirror = mirror;
`endif

    vga_scaled_addr_gen dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    vga_scaled_addr_gen #(.SCALE_X(32), .SCALE_Y(3), .RD_LAT(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // Reference model state, one slot per instance.
    int  p_sx [2];
    int  p_sy [2];
    int  p_lat[2];
    bit  m_run[2];
    int  m_lines[2];
    int  m_pix[2];
    bit  m_mir[2];
    bit  m_hist[2][4];
    int  m_prev_y;
    int  e_addr[2];
    bit  e_in[2];
    bit  e_ls[2];
    bit  e_fs;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_y = 0;
        e_fs     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_run[i]   = 1'b0;
            m_lines[i] = 0;
            m_pix[i]   = 0;
            m_mir[i]   = 1'b0;
            for (int k = 0; k < 4; k++) m_hist[i][k] = 1'b0;
            e_addr[i]  = 0;
            e_in[i]    = 1'b0;
            e_ls[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input int x, input int y);
        bit act, fs, la, mir_in, raw;
        int col, row, ce, re;
        act = (x < SCREEN_X) && (y < SCREEN_Y);
        fs  = (x == 0) && (y == 0);
        la  = act && (x == 0) && (y != m_prev_y) && (y != 0);
`ifdef VGA_SCALED_MIRROR_EN
        mir_in = mirror;
`else
        mir_in = 1'b0;
`endif
        e_fs = fs;
        for (int i = 0; i < 2; i++) begin
            e_ls[i] = 1'b0;
            if (fs) begin
                m_run[i]   = 1'b1;
                m_lines[i] = 0;
                m_pix[i]   = 0;
                m_mir[i]   = mir_in;
            end else if (m_run[i] && act) begin
                if (la) begin
                    m_lines[i]++;
                    m_pix[i] = 0;
                    e_ls[i]  = 1'b1;
                end else if (x != 0) begin
                    m_pix[i]++;
                end
            end
            col = m_pix[i] / p_sx[i];
            if (col > IMG_W) col = IMG_W;
            row = m_lines[i] / p_sy[i];
            if (row > IMG_H) row = IMG_H;
            raw = m_run[i] && act && (col < IMG_W) && (row < IMG_H);
            ce  = (col > IMG_W - 1) ? IMG_W - 1 : col;
            if (m_mir[i]) ce = IMG_W - 1 - ce;
            re  = (row > IMG_H - 1) ? IMG_H - 1 : row;
            e_addr[i] = re * IMG_W + ce;
            for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = raw;
            e_in[i] = m_hist[i][p_lat[i]];
        end
        m_prev_y = y;
    endtask

    task automatic compare();
        check("a_addr",   int'(if_a.mem_addr),    e_addr[0]);
        check("a_in_img", int'(if_a.in_image),    int'(e_in[0]));
        check("a_line",   int'(if_a.line_start),  int'(e_ls[0]));
        check("a_frame",  int'(if_a.frame_start), int'(e_fs));
        check("b_addr",   int'(if_b.mem_addr),    e_addr[1]);
        check("b_in_img", int'(if_b.in_image),    int'(e_in[1]));
        check("b_line",   int'(if_b.line_start),  int'(e_ls[1]));
        check("b_frame",  int'(if_b.frame_start), int'(e_fs));
    endtask

    task automatic cycle(input int x, input int y, input bit r);
        @(negedge clk);
        rst   = r;
        pos_x = 12'(x);
        pos_y = 12'(y);
        if (r) model_reset();
        else   model_step(x, y);
        @(posedge clk);
        #1;
        compare();
    endtask

    // One scan: short random lines, full sweeps on boundary rows, random blanking; optional reset mid-line.
    task automatic run_frame(input int n_lines, input bit fm, input int rst_line);
        for (int y = 0; y < n_lines; y++) begin
            int len;
            bit full;
            full = (y == 0) || (y == 63) || (y == 64) || (y == 767) || ($urandom_range(0, 99) == 0);
            len  = full ? SCREEN_X : int'($urandom_range(1, 40));
            if (y == rst_line) len = 500;
            for (int x = 0; x < len; x++) begin
                if (x == 0 && y == 0) mirror = fm;
                else                  mirror = 1'($urandom_range(0, 1));
                cycle(x, y, (y == rst_line) && (x == 300 || x == 301));
            end
            if (y == 100) cycle(1100, 100, 1'b0);
            repeat ($urandom_range(0, 3)) cycle(1024 + int'($urandom_range(0, 319)), y, 1'b0);
        end
        repeat ($urandom_range(2, 6))
            cycle(int'($urandom_range(0, 1343)), 768 + int'($urandom_range(0, 37)), 1'b0);
    endtask

    initial begin
        p_sx[0] = 64; p_sy[0] = 64; p_lat[0] = 1;
        p_sx[1] = 32; p_sy[1] = 3;  p_lat[1] = 0;
        model_reset();

        repeat (3) cycle(0, 0, 1'b1);
        // Mid-frame positions after reset: must stay idle until a frame start.
        for (int x = 0; x < 30; x++) cycle(x, 5, 1'b0);

        run_frame(768, 1'b0, -1);
        run_frame(25, 1'b1, 11);
        run_frame(131, 1'b1, -1);
        run_frame(6, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vga_scaled_addr_gen.md
Name: vga_scaled_addr_gen

Overview:
- Sequential frame-buffer address generator between the VGA_Driver1024x768 position outputs and the read port of buffer_ram_dp.
- Maps each displayed pixel to a memory address for a small image upscaled by independent integer factors in X and Y.
- Uses running counters and a row-base accumulator, with no divider or multiplier.
- Provides a region flag aligned to the RAM read latency, plus line and frame strobes.

Parameters:
- SCREEN_X, 1024: active display width in pixels
- SCREEN_Y, 768: active display height in lines
- IMG_W, 16: stored image width in pixels
- IMG_H, 12: stored image height in lines
- AW, 8: memory address width; must satisfy 2^AW >= IMG_W*IMG_H
- SCALE_X, 64: horizontal replication factor, >= 1
- SCALE_Y, 64: vertical replication factor, >= 1
- RD_LAT, 1: buffer_ram_dp read latency in clk cycles (0..3) used to delay in_image

Ports:
- clk  in  1  pixel clock, the same clock as the VGA driver and the RAM read port
- rst  in  1  synchronous, active-high reset
- pos_x  in  12  next-pixel X position from the VGA driver
- pos_y  in  12  next-pixel Y position from the VGA driver
- mem_addr  out  AW  registered read address to buffer_ram_dp addr_out
- in_image  out  1  high when the pixel arriving from RAM this cycle belongs to the image area
- line_start  out  1  one-cycle pulse on the first active pixel of each line
- frame_start  out  1  one-cycle pulse at pos_x==0, pos_y==0

Behaviour:
- Reset: on a clk edge with rst=1, every register and output is cleared.
  - mem_addr=0, in_image=0, line_start=0, frame_start=0.
  - Internal counters cleared: sub_x, col, sub_y, row, row_base.
  - prev_y register cleared; in_image delay line cleared.
  - Reset asserted mid-frame takes effect on the next edge. After release, output stays idle until the next frame_start; no partial-frame addressing.
- Active region: pos_x < SCREEN_X and pos_y < SCREEN_Y. Outside it, all counters hold and the internal in_image_raw=0.
- Frame start: pos_x==0 and pos_y==0.
  - Counters load to zero.
  - mem_addr is set to 0 on the next edge.
  - frame_start pulses for 1 cycle.
- Line advance: pos_x==0 and pos_y!=prev_y and pos_y!=0.
  - sub_x and col are cleared, and line_start pulses.
  - sub_y increments. At sub_y==SCALE_Y-1 it wraps to 0, row increments, and row_base += IMG_W.
  - prev_y updates every cycle.
- Pixel advance, for each active pixel with pos_x != 0:
  - sub_x increments.
  - At sub_x==SCALE_X-1, sub_x wraps to 0 and col increments.
- Saturation:
  - col stops at IMG_W and row stops at IMG_H; neither wraps.
  - When col>=IMG_W or row>=IMG_H, in_image_raw=0.
  - mem_addr then holds the last valid address of the current line. The display colour outside the image is the top level's choice.
- Address: mem_addr <= row_base + col_eff, where col_eff=min(col,IMG_W-1) and row is clamped the same way.
  - Latency is 1 cycle from pos_x/pos_y to mem_addr.
  - The sum is computed at AW bits; truncation is impossible given the AW constraint.
- Alignment: in_image = in_image_raw delayed by 1+RD_LAT cycles, so it is valid alongside data_out.
- Simultaneous events: frame start overrides line advance, and line advance overrides pixel advance.
- Degenerate scale: SCALE_X=1 increments col on every active pixel; SCALE_Y=1 increments row on every line.

Optional Feature:
- Macro: VGA_SCALED_MIRROR_EN.
- Defined:
  - Adds input port mirror (1 bit), sampled at frame_start only, so the mode is constant for a whole frame.
  - When the latched value is 1, col_eff = IMG_W-1-min(col,IMG_W-1), giving a horizontally mirrored image.
  - The latched mirror register resets to 0.
- Undefined: no mirror port exists, and col_eff is as above (no mirroring).

Test Plan:
- Reset mid-line, with rst=1 at pos_x=300 for 2 cycles:
  - mem_addr=0, in_image=0 and no strobes until pos_x=0, pos_y=0.
  - Then frame_start=1 for one cycle.
- Defaults, line 0: pos_x sweeps 0..1023 at pos_y=0.
  - mem_addr steps 0,1,...,15, each value held for 64 cycles.
  - in_image=1 throughout, delayed 2 cycles.
- Defaults, vertical: pos_y=63 → row 0 (mem_addr 0..15); pos_y=64 → mem_addr 16..31; pos_y=767 → mem_addr 176..191.
- Saturation: SCALE_X=32 (image 512 wide).
  - For pos_x=512..1023, in_image=0 and mem_addr holds at row_base+15.
  - Next line restarts at row_base+0.
- Blanking: pos_x=1100, pos_y=100 → counters unchanged, in_image=0. Then pos_x=0, pos_y=101 → line_start=1.
- VGA_SCALED_MIRROR_EN with mirror=1 latched at frame_start: line 0 gives mem_addr 15,14,...,0. A mirror toggle mid-frame has no effect until the next frame.
